// File: rtl/alu_issue_queue_pkg.sv
// Shared constants, opcode encoding and the queued request record for the ALU issue queue.
package alu_issue_queue_pkg;

  localparam int WORD_SIZE    = 19;
  localparam int OPCODE_SIZE  = 5;
  localparam int REG_ADDR_W_D = 4;

  typedef enum logic [OPCODE_SIZE-1:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_MUL = 5'd2,
    OP_DIV = 5'd3,
    OP_INC = 5'd4,
    OP_DEC = 5'd5
  } opcode_e;

  typedef struct packed {
    opcode_e                 opcode;
    logic [WORD_SIZE-1:0]    op1;
    logic [WORD_SIZE-1:0]    op2;
    logic [REG_ADDR_W_D-1:0] rd;
  } alu_req_t;

  function automatic logic is_arith(input logic [OPCODE_SIZE-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_INC, OP_DEC: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Decode-side request channel, arithmetic-unit link and writeback channel of the issue queue.
interface alu_issue_queue_if #(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = alu_issue_queue_pkg::REG_ADDR_W_D
);
  import alu_issue_queue_pkg::*;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [OPCODE_SIZE-1:0] in_opcode;
  logic [WORD_SIZE-1:0]   in_op1;
  logic [WORD_SIZE-1:0]   in_op2;
  logic [REG_ADDR_W-1:0]  in_rd;
  logic [OPCODE_SIZE-1:0] au_opcode;
  logic [WORD_SIZE-1:0]   au_operand_1;
  logic [WORD_SIZE-1:0]   au_operand_2;
  logic [WORD_SIZE-1:0]   au_out;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [REG_ADDR_W-1:0]  wb_rd;
  logic [WORD_SIZE-1:0]   wb_data;
  logic                   wb_err;
  logic [CNT_W-1:0]       count;

  modport slave (
    input  in_valid, in_opcode, in_op1, in_op2, in_rd, au_out, wb_ready,
    output in_ready, au_opcode, au_operand_1, au_operand_2,
           wb_valid, wb_rd, wb_data, wb_err, count
  );

  modport master (
    output in_valid, in_opcode, in_op1, in_op2, in_rd, au_out, wb_ready,
    input  in_ready, au_opcode, au_operand_1, au_operand_2,
           wb_valid, wb_rd, wb_data, wb_err, count
  );

endinterface

// File: rtl/alu_issue_queue_sync_fifo.sv
// Synchronous FIFO with registered head; push and pop are assumed pre-qualified by the caller.
module sync_fifo
  import alu_issue_queue_pkg::*;
#(
  parameter type T     = alu_req_t,
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  T                         data_i,
  output T                         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers are exactly log2(DEPTH) wide, so wrap is the natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/alu_issue_queue.sv
// Issue queue: buffers requests, drives the head to the arithmetic unit and registers
// the result (or a trap) into a one-entry writeback stage.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = REG_ADDR_W_D
) (
  input logic               clk,
  input logic               rst,
  alu_issue_queue_if.slave  bus
);
  alu_req_t push_req, head, au_req;
  logic     push, launch, full, empty;

  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [WORD_SIZE-1:0]  wb_data_q, wb_data_d;
  logic                  wb_err_q, wb_err_d;

  assign push_req = '{opcode: opcode_e'(bus.in_opcode), op1: bus.in_op1,
                      op2: bus.in_op2, rd: bus.in_rd};
  assign push     = bus.in_valid && !full;
  assign launch   = !empty && (!wb_valid_q || bus.wb_ready);

  sync_fifo #(.T(alu_req_t), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (launch),
    .data_i  (push_req),
    .head_o  (head),
    .count_o (bus.count),
    .full_o  (full),
    .empty_o (empty)
  );

  // An empty queue presents a zero request so the arithmetic unit idles on a NOP.
  assign au_req           = empty ? '0 : head;
  assign bus.in_ready     = !full;
  assign bus.au_opcode    = au_req.opcode;
  assign bus.au_operand_1 = au_req.op1;
  assign bus.au_operand_2 = au_req.op2;

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_err_d   = wb_err_q;
    if (launch) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = head.rd;
      if (!is_arith(head.opcode)) begin
        wb_data_d = '0;
        wb_err_d  = 1'b1;
      end else if (head.opcode == OP_DIV && head.op2 == '0) begin
        wb_data_d = '1;
        wb_err_d  = 1'b1;
      end else begin
        wb_data_d = bus.au_out;
        wb_err_d  = 1'b0;
      end
    end else if (bus.wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_err   = wb_err_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural arithmetic unit and a result scoreboard.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [19:0] exp_q [$];
  logic [19:0] e;

  alu_issue_queue_if #(.DEPTH(4), .REG_ADDR_W(4)) bus ();
  alu_issue_queue #(.DEPTH(4), .REG_ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural arithmetic unit, combinational from the au_* outputs.
  always_comb begin
    case (bus.au_opcode)
      5'd0:    bus.au_out = bus.au_operand_1 + bus.au_operand_2;
      5'd1:    bus.au_out = bus.au_operand_1 - bus.au_operand_2;
      5'd2:    bus.au_out = 19'(bus.au_operand_1 * bus.au_operand_2);
      5'd3:    bus.au_out = (bus.au_operand_2 == '0) ? '0 : bus.au_operand_1 / bus.au_operand_2;
      5'd4:    bus.au_out = bus.au_operand_1 + 19'd1;
      5'd5:    bus.au_out = bus.au_operand_1 - 19'd1;
      default: bus.au_out = '0;
    endcase
  end

  // Expected {err, data} for one request.
  function automatic logic [19:0] ref_res(input logic [4:0] op, input logic [18:0] a, input logic [18:0] b);
    logic [18:0] r;
    case (op)
      5'd0: r = a + b;
      5'd1: r = a - b;
      5'd2: r = 19'(a * b);
      5'd3: begin
        if (b == 0) return {1'b1, 19'h7FFFF};
        r = a / b;
      end
      5'd4: r = a + 19'd1;
      5'd5: r = a - 19'd1;
      default: return 20'h0_0000 | 20'h8_0000;
    endcase
    return {1'b0, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] op, input logic [18:0] a, input logic [18:0] b, input logic [3:0] rd);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_op1    = a;
    bus.in_op2    = b;
    bus.in_rd     = rd;
    step();
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    logic [4:0]  op;
    logic [18:0] a, b;
    logic [3:0]  rd;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_op1 = '0; bus.in_op2 = '0;
    bus.in_rd = '0; bus.wb_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_wb_valid", 32'(bus.wb_valid), 0);

    // Reset mid-stream with count=3 and a held writeback result
    push(5'd0, 19'd1, 19'd1, 4'd1);
    push(5'd0, 19'd2, 19'd2, 4'd2);
    push(5'd0, 19'd3, 19'd3, 4'd3);
    push(5'd0, 19'd4, 19'd4, 4'd4);
    chk("pre_rst_count", 32'(bus.count), 3);
    chk("pre_rst_wb_valid", 32'(bus.wb_valid), 1);
    rst = 1'b1;
    #2;
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_wb_valid", 32'(bus.wb_valid), 0);
    chk("mid_rst_wb_data", 32'(bus.wb_data), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_count", 32'(bus.count), 0);
    chk("post_rst_wb_valid", 32'(bus.wb_valid), 0);

    // Single ADD latency
    bus.wb_ready = 1'b1;
    push(5'd0, 19'd5, 19'd7, 4'd2);
    chk("add_wb_valid_early", 32'(bus.wb_valid), 0);
    chk("add_count_1", 32'(bus.count), 1);
    step();
    chk("add_wb_valid", 32'(bus.wb_valid), 1);
    chk("add_wb_data", 32'(bus.wb_data), 12);
    chk("add_wb_rd", 32'(bus.wb_rd), 2);
    chk("add_wb_err", 32'(bus.wb_err), 0);
    chk("add_count_0", 32'(bus.count), 0);
    step();
    chk("add_wb_clear", 32'(bus.wb_valid), 0);

    // Backpressure fill then drain in order
    bus.wb_ready = 1'b0;
    push(5'd2, 19'd3, 19'd4, 4'd1);
    push(5'd4, 19'd9, 19'd0, 4'd3);
    push(5'd5, 19'd0, 19'd0, 4'd4);
    push(5'd1, 19'd10, 19'd3, 4'd5);
    push(5'd0, 19'd1, 19'd1, 4'd6);
    chk("full_count", 32'(bus.count), 4);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk("hold_data", 32'(bus.wb_data), 12);
    step();
    chk("hold_data_2", 32'(bus.wb_data), 12);
    chk("hold_rd", 32'(bus.wb_rd), 1);
    chk("hold_count", 32'(bus.count), 4);
    bus.wb_ready = 1'b1;
    step();
    chk("drain_inc", 32'(bus.wb_data), 10);
    chk("drain_inc_rd", 32'(bus.wb_rd), 3);
    chk("drain_cnt3", 32'(bus.count), 3);
    step();
    chk("drain_dec", 32'(bus.wb_data), 32'h7FFFF);
    chk("drain_cnt2", 32'(bus.count), 2);
    step();
    chk("drain_sub", 32'(bus.wb_data), 7);
    step();
    chk("drain_add", 32'(bus.wb_data), 2);
    chk("drain_add_rd", 32'(bus.wb_rd), 6);
    chk("drain_cnt0", 32'(bus.count), 0);
    step();
    chk("drain_idle", 32'(bus.wb_valid), 0);

    // Divide traps
    push(5'd3, 19'd100, 19'd0, 4'd7);
    push(5'd3, 19'd100, 19'd7, 4'd8);
    chk("div0_data", 32'(bus.wb_data), 32'h7FFFF);
    chk("div0_err", 32'(bus.wb_err), 1);
    chk("div0_rd", 32'(bus.wb_rd), 7);
    step();
    chk("div7_data", 32'(bus.wb_data), 14);
    chk("div7_err", 32'(bus.wb_err), 0);
    chk("div7_rd", 32'(bus.wb_rd), 8);
    step();

    // Non-arithmetic opcode trap, then SUB wrap
    push(5'h1F, 19'd3, 19'd4, 4'd9);
    push(5'd1, 19'd3, 19'd4, 4'd10);
    chk("bad_op_data", 32'(bus.wb_data), 0);
    chk("bad_op_err", 32'(bus.wb_err), 1);
    step();
    chk("sub_wrap_data", 32'(bus.wb_data), 32'h7FFFF);
    chk("sub_wrap_err", 32'(bus.wb_err), 0);
    chk("sub_wrap_rd", 32'(bus.wb_rd), 10);
    step();

    // Sustained push/launch around count=DEPTH-1 with random writeback stalls
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 19'(i * 11 + 1);
      b = 19'(i + 2);
      exp_q.push_back(ref_res(5'd0, a, b));
      push(5'd0, a, b, 4'(i));
    end
    chk("t6_setup_count", 32'(bus.count), 3);
    for (int i = 0; i < 20; i++) begin
      op = 5'($urandom_range(0, 5));
      a  = 19'($urandom);
      b  = 19'($urandom_range(0, 3));
      rd = 4'($urandom);
      bus.in_valid  = 1'b1;
      bus.in_opcode = op;
      bus.in_op1    = a;
      bus.in_op2    = b;
      bus.in_rd     = rd;
      bus.wb_ready  = 1'($urandom_range(0, 1));
      if (bus.in_ready) exp_q.push_back(ref_res(op, a, b));
      if (bus.wb_valid && bus.wb_ready) begin
        e = exp_q.pop_front();
        chk("t6_result", {12'd0, bus.wb_err, bus.wb_data}, {12'd0, e});
      end
      step();
      chk("t6_count_bound", 32'(bus.count <= 3'd4), 1);
    end
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 12 && (exp_q.size() != 0 || bus.wb_valid); i++) begin
      if (bus.wb_valid) begin
        if (exp_q.size() == 0) chk("t6_extra_result", 32'(bus.wb_valid), 0);
        else begin
          e = exp_q.pop_front();
          chk("t6_drain", {12'd0, bus.wb_err, bus.wb_data}, {12'd0, e});
        end
      end
      step();
    end
    chk("t6_scoreboard_empty", 32'(exp_q.size()), 0);
    chk("t6_final_count", 32'(bus.count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
